proc_mem: RTL and testbench

- Parametrised multicycle processor with DATA_W-bit data path, eight registers r0..r7 and r7 acting as the program counter.
- Fetches its own 16-bit instructions from an external synchronous memory with one-cycle read latency, so Run no longer carries instruction words.
- Adds load, store, logical AND, conditional branch and condition flags (z, n, c) to the existing mv/mvt/add/sub set.
- Sits between the top-level memory/IO decoder and the board-level clock/reset.

---
 rtl/proc_mem.sv | 161 ++++++++++++++++
 tb/tb_proc_mem.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_mem.sv
// Multicycle processor: fetches 16-bit instructions from a one-cycle-latency
// synchronous memory, executes mv/mvt/add/sub/ld/st/and/b{cond} with z/n/c flags.
module proc_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              W,
  output logic              Done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {F0, F1, F2, E1, E2, E3} state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_B   = 3'b111;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] r [0:7];
  logic [15:0]       ir;
  logic [DATA_W-1:0] a, g;
  logic              z, n, c;

  logic [2:0]        op, rx, ry;
  logic              imm;
  logic [DATA_W-1:0] dext, mvt_val, opnd;
  logic [DATA_W:0]   sum;
  logic              taken;
  logic              alu_op;

  assign op      = ir[15:13];
  assign imm     = ir[12];
  assign rx      = ir[11:9];
  assign ry      = ir[2:0];
  assign dext    = {{(DATA_W-9){ir[8]}}, ir[8:0]};
  assign mvt_val = {ir[7:0], {(DATA_W-8){1'b0}}};
  assign opnd    = imm ? dext : r[ry];
  assign alu_op  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  assign dbg_state = state;

  // sub is A + ~op + 1, so the carry out reads as "no borrow"; and keeps c
  always_comb begin
    sum = {c, a & opnd};
    case (op)
      OP_ADD:  sum = {1'b0, a} + {1'b0, opnd};
      OP_SUB:  sum = {1'b0, a} + {1'b0, ~opnd} + (DATA_W+1)'(1);
      default: sum = {c, a & opnd};
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (rx)
      3'b000:  taken = 1'b1;
      3'b001:  taken = z;
      3'b010:  taken = ~z;
      3'b011:  taken = ~c;
      3'b100:  taken = c;
      3'b101:  taken = ~n;
      3'b110:  taken = n;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= F0;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Done      = 1'b0;
    case (state)
      F0: if (Run) state_nxt = F1;
      F1: state_nxt = F2;
      F2: state_nxt = E1;
      E1: begin
        if (op == OP_MV || op == OP_MVT || op == OP_B) begin
          Done      = 1'b1;
          state_nxt = F0;
        end else begin
          state_nxt = E2;
        end
      end
      E2: state_nxt = E3;
      E3: begin
        Done      = 1'b1;
        state_nxt = F0;
      end
      default: state_nxt = F0;
    endcase
  end

  // W is raised leaving E1 so it is high for the whole of E2 only
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 7; i++) r[i] <= '0;
      r[7] <= RESET_PC;
      ir   <= '0;
      a    <= '0;
      g    <= '0;
      z    <= 1'b0;
      n    <= 1'b0;
      c    <= 1'b0;
      ADDR <= '0;
      DOUT <= '0;
      W    <= 1'b0;
    end else begin
      case (state)
        F0: begin
          if (Run) begin
            ADDR <= r[7][ADDR_W-1:0];
            r[7] <= r[7] + DATA_W'(1);
          end
        end
        F2: ir <= DIN[15:0];
        E1: begin
          case (op)
            OP_MV:  r[rx] <= opnd;
            OP_MVT: r[rx] <= mvt_val;
            OP_B:   if (taken) r[7] <= r[7] + dext;
            OP_LD:  ADDR <= r[ry][ADDR_W-1:0];
            OP_ST: begin
              ADDR <= r[ry][ADDR_W-1:0];
              DOUT <= r[rx];
              W    <= 1'b1;
            end
            default: a <= r[rx];
          endcase
        end
        E2: begin
          W <= 1'b0;
          if (alu_op) begin
            g <= sum[DATA_W-1:0];
            z <= (sum[DATA_W-1:0] == '0);
            n <= sum[DATA_W-1];
            c <= sum[DATA_W];
          end
        end
        E3: begin
          if (alu_op)          r[rx] <= g;
          else if (op == OP_LD) r[rx] <= DIN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_mem.sv
// Bench for proc_mem: instruction-level reference model, synchronous memory
// model, directed program plus randomized instruction stream.
module tb_proc_mem;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam logic [DW-1:0] RPC = '0;
  localparam logic [2:0] S_F0 = 3'd0;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Run = 1'b0;
  logic [DW-1:0] DIN;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] DOUT;
  logic          W, Done;
  logic [2:0]    dbg_state;

  int vectors = 0;
  int errs = 0;

  // valid/ready: none; memory follows ADDR/W with a one-cycle registered read
  logic          prog_we = 1'b0;
  logic          mem_clr = 1'b1;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_data = '0;
  logic [DW-1:0] mem [0:65535];

  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] mr [8];
  logic          mz, mn, mc;

  proc_mem #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .ADDR(ADDR),
    .DOUT(DOUT), .W(W), .Done(Done), .dbg_state(dbg_state)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= '0;
    end else begin
      DIN <= mem[ADDR];
      if (W) mem[ADDR] <= DOUT;
      if (prog_we) mem[prog_addr] <= prog_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) mr[i] = '0;
    mr[7] = RPC;
    mz = 1'b0; mn = 1'b0; mc = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s r%0d", tag, i), 64'(dut.r[i]), 64'(mr[i]));
    chk({tag, " z"}, 64'(dut.z), 64'(mz));
    chk({tag, " n"}, 64'(dut.n), 64'(mn));
    chk({tag, " c"}, 64'(dut.c), 64'(mc));
  endtask

  // Instruction-set semantics; returns cycle count, store details and last bus address
  function automatic void model_exec(input logic [15:0] ins, output int cyc, output bit is_st,
                                     output logic [AW-1:0] st_a, output logic [DW-1:0] st_d,
                                     output logic [AW-1:0] last_a);
    int x, y, sd;
    bit tk;
    logic [DW-1:0] d, opnd, res;
    longint unsigned full, lim;
    x = int'(ins[11:9]);
    y = int'(ins[2:0]);
    sd = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
    d = DW'(sd);
    lim = 64'd1 << DW;
    last_a = mr[7][AW-1:0];
    mr[7] = mr[7] + 1;
    opnd = ins[12] ? d : mr[y];
    is_st = 0; st_a = 'x; st_d = 'x;
    cyc = 4;
    case (ins[15:13])
      3'd0: mr[x] = opnd;
      3'd1: mr[x] = DW'(ins[7:0]) << (DW - 8);
      3'd2, 3'd3, 3'd6: begin
        cyc = 6;
        if (ins[15:13] == 3'd2) begin
          full = longint'(mr[x]) + longint'(opnd);
          res = DW'(full);
          mc = (full >= lim);
        end else if (ins[15:13] == 3'd3) begin
          res = mr[x] - opnd;
          mc = (mr[x] >= opnd);
        end else begin
          res = mr[x] & opnd;
        end
        mz = (res == 0);
        mn = res[DW-1];
        mr[x] = res;
      end
      3'd4: begin
        cyc = 6;
        last_a = mr[y][AW-1:0];
        mr[x] = ref_mem[last_a];
      end
      3'd5: begin
        cyc = 6;
        is_st = 1;
        st_a = mr[y][AW-1:0];
        st_d = mr[x];
        last_a = st_a;
        ref_mem[st_a] = st_d;
      end
      default: begin
        case (x)
          0: tk = 1;
          1: tk = mz;
          2: tk = !mz;
          3: tk = !mc;
          4: tk = mc;
          5: tk = !mn;
          6: tk = mn;
          default: tk = 0;
        endcase
        if (tk) mr[7] = mr[7] + d;
      end
    endcase
  endfunction

  logic [AW-1:0] last_addr;

  // Called at a negedge with the DUT in F0; returns at the next F0 negedge
  task automatic exec(input logic [15:0] ins, input bit drop_run);
    logic [AW-1:0] pc, sa;
    logic [DW-1:0] sdat;
    int ecyc, cyc, wcnt;
    bit is_st, done_seen;
    pc = mr[7][AW-1:0];
    prog_we = 1'b1; prog_addr = pc; prog_data = DW'(ins);
    ref_mem[pc] = DW'(ins);
    model_exec(ins, ecyc, is_st, sa, sdat, last_addr);
    Run = 1'b1;
    cyc = 1; wcnt = 0; done_seen = 0;
    chk("f0_done", 64'(Done), 64'd0);
    while (!done_seen && cyc < 12) begin
      @(negedge Clock);
      cyc++;
      prog_we = 1'b0;
      if (cyc == 2) begin
        chk("fetch_addr", 64'(ADDR), 64'(pc));
        if (drop_run) Run = 1'b0;
      end
      if (W === 1'b1) begin
        wcnt++;
        chk("st_addr", 64'(ADDR), 64'(sa));
        chk("st_data", 64'(DOUT), 64'(sdat));
      end
      if (Done === 1'b1) done_seen = 1;
    end
    chk($sformatf("done_cycle %04h", ins), 64'(cyc), 64'(ecyc));
    chk("w_pulses", 64'(wcnt), is_st ? 64'd1 : 64'd0);
    @(negedge Clock);
    check_state($sformatf("after %04h", ins));
    if (drop_run) begin
      repeat (3) begin
        @(negedge Clock);
        chk("hold_state", 64'(dbg_state), 64'(S_F0));
        chk("hold_addr", 64'(ADDR), 64'(last_addr));
        chk("hold_done", 64'(Done), 64'd0);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " W"}, 64'(W), 64'd0);
    chk({tag, " Done"}, 64'(Done), 64'd0);
    chk({tag, " state"}, 64'(dbg_state), 64'(S_F0));
    chk({tag, " r7"}, 64'(dut.r[7]), 64'(RPC));
  endtask

  initial begin
    logic [DW-1:0] st_val;
    bit w_seen;
    model_reset();
    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
    repeat (2) @(negedge Clock);
    check_reset("reset");
    check_state("reset");
    chk("reset ADDR", 64'(ADDR), 64'd0);
    chk("reset DOUT", 64'(DOUT), 64'd0);
    chk("reset IR", 64'(dut.ir), 64'd0);
    chk("reset A", 64'(dut.a), 64'd0);
    chk("reset G", 64'(dut.g), 64'd0);
    mem_clr = 1'b0;
    Resetn = 1'b1;

    // Directed program
    exec(16'h1005, 0);                   // mv r0,#5
    chk("r0_is_5", 64'(dut.r[0]), 64'd5);
    exec(16'h32AB, 0);                   // mvt r1,#0xAB
    exec(16'h52CD, 0);                   // add r1,#0xCD
    chk("r1_abcd", 64'(dut.r[1]), (64'hAB << (DW - 8)) | 64'hCD);
    chk("add_n", 64'(dut.n), 64'd1);
    chk("add_c", 64'(dut.c), 64'd0);
    exec(16'h15FF, 0);                   // mv r2,#-1
    exec(16'h7401, 0);                   // sub r2,#1
    chk("sub1_c", 64'(dut.c), 64'd1);
    exec(16'h6402, 0);                   // sub r2,r2
    chk("sub2_z", 64'(dut.z), 64'd1);
    exec(16'hE3FD, 0);                   // beq #-3
    exec(16'hE5FD, 0);                   // bne #-3
    exec(16'h1640, 0);                   // mv r3,#0x40
    exec(16'h3812, 0);                   // mvt r4,#0x12
    exec(16'h5834, 0);                   // add r4,#0x34
    exec(16'hA803, 0);                   // st r4,[r3]
    exec(16'h8A03, 0);                   // ld r5,[r3]
    chk("r5_1234", 64'(dut.r[5]), 64'h1234 << (DW - 16));

    // Run low in F0 freezes everything
    Run = 1'b0;
    repeat (10) begin
      @(negedge Clock);
      chk("freeze_state", 64'(dbg_state), 64'(S_F0));
      chk("freeze_addr", 64'(ADDR), 64'(last_addr));
      chk("freeze_done", 64'(Done), 64'd0);
    end
    check_state("freeze");

    // Run dropped mid-add
    exec(16'h5201, 1);                   // add r1,#1

    // Randomized instruction stream
    repeat (250) exec(16'($urandom_range(0, 65535)), $urandom_range(0, 15) == 0);

    // Reset during st E2 aborts the write
    exec(16'h1255, 0);                   // mv r1,#0x55
    exec(16'h1420, 0);                   // mv r2,#0x20
    st_val = ref_mem[16'h20];
    prog_we = 1'b1; prog_addr = mr[7][AW-1:0]; prog_data = DW'(16'hA202);
    ref_mem[mr[7][AW-1:0]] = DW'(16'hA202);
    Run = 1'b1;
    w_seen = 0;
    for (int k = 0; k < 10 && !w_seen; k++) begin
      @(negedge Clock);
      prog_we = 1'b0;
      if (W === 1'b1) w_seen = 1;
    end
    chk("st_w_reached", 64'(w_seen), 64'd1);
    Resetn = 1'b0;
    #1;
    model_reset();
    check_reset("abort");
    check_state("abort");
    @(negedge Clock);
    @(negedge Clock);
    chk("abort_no_write", 64'(mem[16'h20]), 64'(st_val));
    Resetn = 1'b1;
    repeat (20) exec(16'($urandom_range(0, 65535)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
